// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-stage bundle covering the imem request/response bus, redirect input and IF/ID outputs
interface if_fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   id_ready;
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [PC_WIDTH-1:0]    if_pc_out;
  logic                   if_stall;
  modport master (
    input  redirect_valid, redirect_pc, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_instr, if_pc_out, if_stall
  );
  modport slave (
    output redirect_valid, redirect_pc, id_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_instr, if_pc_out, if_stall
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing in-order imem fetches into a credit-bounded prefetch FIFO with redirect flush
module if_fetch_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  DEPTH       = 2
) (
  input logic       clk,
  input logic       rst,
  if_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h13);
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [CW-1:0]          count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d, iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [PC_WIDTH-1:0]    fifo_pc_q [DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc_d [DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr_d [DEPTH];
  logic [PC_WIDTH-1:0]    iq_pc_q [DEPTH];
  logic [PC_WIDTH-1:0]    iq_pc_d [DEPTH];
  logic [CW:0]            used;
  logic                   redir, issue, keep, push, pop;
  assign used          = {1'b0, inflight_q} + {1'b0, count_q};
  assign redir         = bus.redirect_valid;
  assign bus.imem_req  = !rst && !redir && used < (CW+1)'(DEPTH);
  assign bus.imem_addr = pc_q;
  assign issue         = bus.imem_req && bus.imem_gnt;
  assign keep          = bus.imem_rvalid && drop_q == '0;
  assign push          = keep && !redir;
  assign pop           = bus.id_ready && count_q != '0 && !redir;
  assign bus.if_stall  = count_q == '0;
  assign bus.if_instr  = bus.if_stall ? NOP : fifo_instr_q[rd_q];
  assign bus.if_pc_out = bus.if_stall ? '0 : fifo_pc_q[rd_q];
  // next-state: redirect flushes buffers and marks every outstanding fetch as stale
  always_comb begin
    pc_d         = redir ? bus.redirect_pc & ~PC_WIDTH'(3) : issue ? pc_q + PC_WIDTH'(4) : pc_q;
    inflight_d   = inflight_q + CW'(issue) - CW'(bus.imem_rvalid);
    drop_d       = redir ? inflight_q - CW'(bus.imem_rvalid) : drop_q - CW'(bus.imem_rvalid && drop_q != '0);
    count_d      = redir ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d         = redir ? '0 : wr_q + AW'(push);
    rd_d         = redir ? '0 : rd_q + AW'(pop);
    iq_wr_d      = redir ? '0 : iq_wr_q + AW'(issue);
    iq_rd_d      = redir ? '0 : iq_rd_q + AW'(keep);
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    iq_pc_d      = iq_pc_q;
    if (push) begin
      fifo_pc_d[wr_q]    = iq_pc_q[iq_rd_q];
      fifo_instr_d[wr_q] = bus.imem_rdata;
    end
    if (issue) iq_pc_d[iq_wr_q] = pc_q;
  end
  // storage arrays follow their next state; control state is cleared by reset
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
    iq_pc_q      <= iq_pc_d;
    if (rst) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench with an imem model, issue-address and output monitors
module tb_if_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A50000;
  logic clk, rst;
  if_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();
  if_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp, n_err, budget, issue_cnt;
  logic mem_quiet, rsp_en;
  logic [31:0] exp_pc[$], exp_addr[$], mq[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // imem model: grants while budget lasts, answers in order one cycle after issue
  initial begin
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = 0;
    forever begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_gnt) begin
        issue_cnt++;
        if (exp_addr.size() == 0) chk("issue_unexpected", bus.imem_addr, 32'hFFFFFFFF);
        else chk("issue_addr", bus.imem_addr, exp_addr.pop_front());
        mq.push_back(bus.imem_addr);
        if (budget > 0) budget--;
      end
      @(posedge clk);
      #2;
      if (mem_quiet) begin
        mq.delete();
        bus.imem_rvalid = 0;
      end else if (rsp_en && mq.size() > 0) begin
        bus.imem_rvalid = 1;
        bus.imem_rdata = mq.pop_front() ^ KEY;
      end else bus.imem_rvalid = 0;
      bus.imem_gnt = !mem_quiet && budget > 0;
    end
  end

  // output monitor: every consumed head entry is checked against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.id_ready && !bus.redirect_valid && !bus.if_stall) begin
        if (exp_pc.size() == 0) chk("out_unexpected", bus.if_pc_out, 32'hFFFFFFFF);
        else begin
          logic [31:0] p;
          p = exp_pc.pop_front();
          chk("out_pc", bus.if_pc_out, p);
          chk("out_instr", bus.if_instr, p ^ KEY);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    mem_quiet = 1;
    bus.id_ready = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    budget = 0;
    rsp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    issue_cnt = 0;
  endtask

  task automatic release_rst();
    rst = 0;
    mem_quiet = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && (exp_pc.size() != 0 || exp_addr.size() != 0); i++) @(negedge clk);
    chk({name, "_pending_out"}, exp_pc.size(), 0);
    chk({name, "_pending_issue"}, exp_addr.size(), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    issue_cnt = 0;
    rst = 1;
    mem_quiet = 1;
    rsp_en = 1;
    budget = 0;
    bus.id_ready = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_stall", bus.if_stall, 1);
    chk("rst_instr", bus.if_instr, 32'h13);
    chk("rst_pc_out", bus.if_pc_out, 0);
    chk("rst_addr", bus.imem_addr, 0);
    // streaming fetch with downstream always ready
    do_reset();
    budget = 6;
    bus.id_ready = 1;
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    release_rst();
    @(negedge clk);
    chk("t1_stall_c0", bus.if_stall, 1);
    @(negedge clk);
    chk("t1_stall_c1", bus.if_stall, 1);
    @(negedge clk);
    chk("t1_stall_c2", bus.if_stall, 0);
    drain("t1");
    // downstream stalled: credits cap issues at DEPTH
    do_reset();
    budget = 4;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    release_rst();
    repeat (8) step();
    @(negedge clk);
    chk("t2_issues", issue_cnt, 2);
    chk("t2_req_off", bus.imem_req, 0);
    chk("t2_head_pc", bus.if_pc_out, 0);
    chk("t2_head_valid", bus.if_stall, 0);
    step();
    bus.id_ready = 1;
    drain("t2");
    // grant withheld: request and address held stable
    do_reset();
    bus.id_ready = 1;
    exp_addr = '{32'h0};
    exp_pc = '{32'h0};
    release_rst();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_req_hold", bus.imem_req, 1);
      chk("t3_addr_hold", bus.imem_addr, 0);
    end
    step();
    budget = 1;
    drain("t3");
    chk("t3_single_issue", issue_cnt, 1);
    // redirect with two fetches in flight
    do_reset();
    rsp_en = 0;
    budget = 2;
    bus.id_ready = 1;
    exp_addr = '{32'h0, 32'h4, 32'h100, 32'h104};
    exp_pc = '{32'h100, 32'h104};
    release_rst();
    repeat (4) step();
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 0;
    rsp_en = 1;
    budget = 2;
    @(negedge clk);
    chk("t4_stall_after", bus.if_stall, 1);
    drain("t4");
    // redirect coincident with a response and id_ready, unaligned target
    do_reset();
    rsp_en = 0;
    budget = 2;
    bus.id_ready = 1;
    exp_addr = '{32'h0, 32'h4, 32'h100};
    exp_pc = '{32'h100};
    release_rst();
    repeat (4) step();
    rsp_en = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h103;
    step();
    bus.redirect_valid = 0;
    budget = 1;
    @(negedge clk);
    chk("t5_req", bus.imem_req, 1);
    chk("t5_addr", bus.imem_addr, 32'h100);
    chk("t5_stall", bus.if_stall, 1);
    drain("t5");
    // reset while FIFO full
    do_reset();
    budget = 2;
    exp_addr = '{32'h0, 32'h4};
    release_rst();
    repeat (6) step();
    @(negedge clk);
    chk("t6_full_req", bus.imem_req, 0);
    chk("t6_full_pc", bus.if_pc_out, 0);
    chk("t6_full_instr", bus.if_instr, KEY);
    step();
    rst = 1;
    mem_quiet = 1;
    @(negedge clk);
    chk("t6_rst_req", bus.imem_req, 0);
    @(negedge clk);
    chk("t6_rst_stall", bus.if_stall, 1);
    chk("t6_rst_instr", bus.if_instr, 32'h13);
    chk("t6_rst_addr", bus.imem_addr, 0);
    step();
    release_rst();
    @(negedge clk);
    chk("t6_post_req", bus.imem_req, 1);
    chk("t6_post_addr", bus.imem_addr, 0);
    chk("t6_post_stall", bus.if_stall, 1);
    chk("t6_leftover_issue", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
